// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the CPU datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
   parameter int unsigned STATE_W = 4
);
   logic [4:0]         op;
   logic               zero;
   logic               mem_ready;
   logic               pcwrite;
   logic [1:0]         pcsrc;
   logic               irwrite;
   logic               iord;
   logic               memread;
   logic               memwrite;
   logic               regwrite;
   logic [1:0]         regdst;
   logic               memtoreg;
   logic               alusrca;
   logic [1:0]         alusrcb;
   logic [3:0]         alucontrol;
   logic               illegal;
   logic [STATE_W-1:0] state;

   modport master (
      input  op, zero, mem_ready,
      output pcwrite, pcsrc, irwrite, iord, memread, memwrite, regwrite,
             regdst, memtoreg, alusrca, alusrcb, alucontrol, illegal, state
   );

   modport slave (
      output op, zero, mem_ready,
      input  pcwrite, pcsrc, irwrite, iord, memread, memwrite, regwrite,
             regdst, memtoreg, alusrca, alusrcb, alucontrol, illegal, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 5-bit-opcode CPU: fetch/decode/execute/memory/writeback
// sequencing, ALU control, illegal-opcode and memory-timeout detection.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned STATE_W     = 4
) (
   input  logic                clk,
   input  logic                reset,
   multicycle_ctrl_if.master   bus
);
   localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EXEC_R  = 4'd2,
      EXEC_I  = 4'd3,
      ALUWB   = 4'd4,
      MEMADDR = 4'd5,
      MEMRD   = 4'd6,
      MEMWB   = 4'd7,
      MEMWR   = 4'd8,
      BRANCH  = 4'd9,
      JUMP    = 4'd10,
      JUMPR   = 4'd11,
      ERROR   = 4'd12
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_c;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign timeout_c = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
   assign bus.state = STATE_W'(state_q);

   // Next state and state-decoded controls; the wait counter clears on any state change.
   always_comb begin
      state_d        = state_q;
      cnt_d          = '0;
      bus.pcwrite    = 1'b0;
      bus.pcsrc      = 2'b00;
      bus.irwrite    = 1'b0;
      bus.iord       = 1'b0;
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.regdst     = 2'b00;
      bus.memtoreg   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.alucontrol = 4'b0000;
      bus.illegal    = 1'b0;

      case (state_q)
         FETCH: begin
            bus.memread = 1'b1;
            bus.alusrcb = 2'b01;
            if (bus.mem_ready) begin
               bus.irwrite = 1'b1;
               bus.pcwrite = 1'b1;
               state_d     = DECODE;
            end else if (timeout_c) begin
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DECODE: begin
            bus.alusrcb = 2'b11;
            case (bus.op) inside
               [5'b01000:5'b10001], 5'b10011, 5'b10100: state_d = EXEC_R;
               5'b10010:                                state_d = JUMPR;
               5'b11000, 5'b11001:                      state_d = EXEC_I;
               5'b11010, 5'b11011:                      state_d = MEMADDR;
               5'b11100, 5'b11101:                      state_d = BRANCH;
               5'b00000, 5'b00111:                      state_d = JUMP;
               default:                                 state_d = ERROR;
            endcase
         end
         EXEC_R: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = 4'(bus.op - 5'd8);
            state_d        = ALUWB;
         end
         EXEC_I: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = 2'b10;
            bus.alucontrol = {3'b000, bus.op[0]};
            state_d        = ALUWB;
         end
         ALUWB: begin
            bus.regwrite = 1'b1;
            // I-type ALU ops are 1100x; everything else reaching here is R-type
            bus.regdst   = (bus.op[4:3] == 2'b11) ? 2'b00 : 2'b01;
            state_d      = FETCH;
         end
         MEMADDR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            state_d     = bus.op[0] ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.iord    = 1'b1;
            bus.memread = 1'b1;
            if (bus.mem_ready)  state_d = MEMWB;
            else if (timeout_c) state_d = ERROR;
            else                cnt_d   = cnt_q + CNT_W'(1);
         end
         MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
            state_d      = FETCH;
         end
         MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
            if (bus.mem_ready)  state_d = FETCH;
            else if (timeout_c) state_d = ERROR;
            else                cnt_d   = cnt_q + CNT_W'(1);
         end
         BRANCH: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = 4'b0001;
            bus.pcsrc      = 2'b01;
            bus.pcwrite    = bus.op[0] ? ~bus.zero : bus.zero;
            state_d        = FETCH;
         end
         JUMP: begin
            bus.pcsrc   = 2'b10;
            bus.pcwrite = 1'b1;
            if (bus.op == 5'b00111) begin
               bus.regwrite = 1'b1;
               bus.regdst   = 2'b10;
            end
            state_d = FETCH;
         end
         JUMPR: begin
            bus.pcsrc   = 2'b11;
            bus.pcwrite = 1'b1;
            state_d     = FETCH;
         end
         ERROR: begin
            bus.illegal = 1'b1;
         end
         default: state_d = ERROR;
      endcase

      // Reset held low masks every control so an aborted instruction leaves nothing asserted
      if (!reset) begin
         bus.pcwrite    = 1'b0;
         bus.pcsrc      = 2'b00;
         bus.irwrite    = 1'b0;
         bus.iord       = 1'b0;
         bus.memread    = 1'b0;
         bus.memwrite   = 1'b0;
         bus.regwrite   = 1'b0;
         bus.regdst     = 2'b00;
         bus.memtoreg   = 1'b0;
         bus.alusrca    = 1'b0;
         bus.alusrcb    = 2'b00;
         bus.alucontrol = 4'b0000;
         bus.illegal    = 1'b0;
      end
   end
endmodule
